// File: rtl/text_mode_pkg.sv
// Shared constants, FSM states and strobe bundle for the 80x30 text-mode glyph fetch path.
package text_mode_pkg;

  localparam int H_ACTIVE      = 640;
  localparam int V_ACTIVE      = 480;
  localparam int WORDS_PER_ROW = 20;
  localparam int CTRL_ADDR     = 600;
  localparam int FETCH_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CTRL_ADDR,
    ST_CTRL_CAP
  } fetch_state_e;

  // Timing strobes travel together; 'active' is vde qualified by the visible width.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic vde;
    logic active;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '{hsync: 1'b1, vsync: 1'b1, vde: 1'b0, active: 1'b0};

  function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] k);
    return word[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/vram_glyph_fetch.sv
// Text-mode pixel generator: VRAM glyph fetch, font lookup and a once-per-frame
// colour register read, producing a 3-clock-latency foreground select and strobes.
module vram_glyph_fetch #(
  parameter int H_ACTIVE      = text_mode_pkg::H_ACTIVE,
  parameter int WORDS_PER_ROW = text_mode_pkg::WORDS_PER_ROW,
  parameter int CTRL_ADDR     = text_mode_pkg::CTRL_ADDR
) (
  input  logic        pixel_clk,
  input  logic        pixel_aresetn,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        vde_in,
  output logic [9:0]  vram_addr,
  input  logic [31:0] vram_rdata,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        pix_fg,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        vde_out,
  output logic [11:0] fgd_rgb,
  output logic [11:0] bkg_rgb
);

  import text_mode_pkg::fetch_state_e;
  import text_mode_pkg::ST_IDLE;
  import text_mode_pkg::ST_CTRL_ADDR;
  import text_mode_pkg::ST_CTRL_CAP;
  import text_mode_pkg::V_ACTIVE;
  import text_mode_pkg::strobes_t;
  import text_mode_pkg::STROBES_IDLE;
  import text_mode_pkg::select_byte;

  fetch_state_e state, state_next;
  logic         trigger;
  logic         capture_en;
  logic [9:0]   text_addr;

  // Only the colour fields of the control word are kept (word bits 24:1).
  logic [23:0]  ctrl_q;

  logic [4:0]   s1_x;
  logic [3:0]   s1_y;
  strobes_t     s1_strb;
  logic [7:0]   glyph;

  logic [7:0]   s2_font;
  logic [2:0]   s2_x;
  logic         s2_inv;
  strobes_t     s2_strb;
  strobes_t     cur_strb;

  assign text_addr = 10'(drawY[9:4]) * 10'(WORDS_PER_ROW) + 10'(drawX[9:5]);
  assign trigger   = !vde_in && (drawY == 10'(V_ACTIVE)) && (drawX == 10'd0);

  assign cur_strb.hsync  = hsync_in;
  assign cur_strb.vsync  = vsync_in;
  assign cur_strb.vde    = vde_in;
  assign cur_strb.active = vde_in && (drawX < 10'(H_ACTIVE));

  always_comb begin
    vram_addr = '0;
    if (state == ST_CTRL_ADDR) begin
      vram_addr = 10'(CTRL_ADDR);
    end else if (vde_in) begin
      vram_addr = text_addr;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The control word is addressed in CTRL_ADDR and arrives from the BRAM during CTRL_CAP.
  always_comb begin
    state_next = state;
    capture_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_next = ST_CTRL_ADDR;
        end
      end
      ST_CTRL_ADDR: begin
        state_next = ST_CTRL_CAP;
      end
      ST_CTRL_CAP: begin
        state_next = ST_IDLE;
        capture_en = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      ctrl_q <= '0;
    end else if (capture_en) begin
      ctrl_q <= vram_rdata[24:1];
    end
  end

  assign fgd_rgb = ctrl_q[23:12];
  assign bkg_rgb = ctrl_q[11:0];

  // Sync strobes reset to their inactive (high) level so outputs never glitch low after reset.
  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      s1_x    <= '0;
      s1_y    <= '0;
      s1_strb <= STROBES_IDLE;
    end else begin
      s1_x    <= drawX[4:0];
      s1_y    <= drawY[3:0];
      s1_strb <= cur_strb;
    end
  end

  assign glyph     = select_byte(vram_rdata, s1_x[4:3]);
  assign font_addr = {glyph[6:0], s1_y};

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      s2_font <= '0;
      s2_x    <= '0;
      s2_inv  <= 1'b0;
      s2_strb <= STROBES_IDLE;
    end else begin
      s2_font <= font_data;
      s2_x    <= s1_x[2:0];
      s2_inv  <= glyph[7];
      s2_strb <= s1_strb;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      pix_fg    <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      vde_out   <= 1'b0;
    end else begin
      pix_fg    <= s2_strb.active & (s2_font[3'd7 - s2_x] ^ s2_inv);
      hsync_out <= s2_strb.hsync;
      vsync_out <= s2_strb.vsync;
      vde_out   <= s2_strb.vde;
    end
  end

endmodule

// File: tb/tb_vram_glyph_fetch.sv
// Self-checking bench for vram_glyph_fetch: BRAM/font models, a frame-level reference
// model compared every cycle, and directed literal checks.
module tb_vram_glyph_fetch;

  logic        pixel_clk = 1'b0;
  logic        pixel_aresetn;
  logic [9:0]  drawX, drawY;
  logic        hsync_in, vsync_in, vde_in;
  logic [9:0]  vram_addr;
  logic [31:0] vram_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        pix_fg, hsync_out, vsync_out, vde_out;
  logic [11:0] fgd_rgb, bkg_rgb;

  logic [31:0] mem  [0:1023];
  logic [7:0]  font [0:2047];

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    bit       live;
    bit       vde;
    bit       hs;
    bit       vs;
    bit       pix;
    bit [6:0] code;
    bit [3:0] y;
  } sample_t;

  sample_t     hist [3];
  int          ctrlCount;
  logic [31:0] capWord;
  logic [11:0] expFgd, expBkg;

  vram_glyph_fetch dut (
    .pixel_clk     (pixel_clk),
    .pixel_aresetn (pixel_aresetn),
    .drawX         (drawX),
    .drawY         (drawY),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .vde_in        (vde_in),
    .vram_addr     (vram_addr),
    .vram_rdata    (vram_rdata),
    .font_addr     (font_addr),
    .font_data     (font_data),
    .pix_fg        (pix_fg),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .vde_out       (vde_out),
    .fgd_rgb       (fgd_rgb),
    .bkg_rgb       (bkg_rgb)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) vram_rdata <= mem[vram_addr];
  assign font_data = font[font_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input logic vde, input logic hs, input logic vs);
    @(posedge pixel_clk);
    #1;
    drawX    = 10'(x);
    drawY    = 10'(y);
    vde_in   = vde;
    hsync_in = hs;
    vsync_in = vs;
  endtask

  task automatic applyBlank(input int n);
    for (int i = 0; i < n; i++) applyStimulus(700, 3, 1'b0, 1'b1, 1'b1);
  endtask

  function automatic void resetModel();
    for (int i = 0; i < 3; i++) begin
      hist[i] = '{live: 1'b0, vde: 1'b0, hs: 1'b1, vs: 1'b1, pix: 1'b0, code: 7'd0, y: 4'd0};
    end
    ctrlCount = 0;
    capWord   = '0;
    expFgd    = '0;
    expBkg    = '0;
  endfunction

  // Word the display must be reading this cycle: control register right after a trigger,
  // otherwise the text cell under the beam (0 outside the active area).
  function automatic logic [9:0] expectedAddr();
    if (ctrlCount == 2) return 10'd600;
    if (!vde_in) return 10'd0;
    return 10'((int'(drawY) / 16) * 20 + int'(drawX) / 32);
  endfunction

  always @(posedge pixel_clk or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      resetModel();
    end else begin : sampleStep
      logic [31:0] word;
      logic [7:0]  gbyte;
      logic [7:0]  row;
      sample_t     s;
      word   = mem[expectedAddr()];
      gbyte  = 8'(word >> (8 * int'(drawX[4:3])));
      row    = font[{gbyte[6:0], drawY[3:0]}];
      s.live = 1'b1;
      s.vde  = vde_in;
      s.hs   = hsync_in;
      s.vs   = vsync_in;
      s.code = gbyte[6:0];
      s.y    = drawY[3:0];
      s.pix  = vde_in && (drawX < 10'd640) && (row[3'd7 - drawX[2:0]] ^ gbyte[7]);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = s;
      if (ctrlCount > 0) begin
        if (ctrlCount == 2) capWord = word;
        ctrlCount--;
        if (ctrlCount == 0) begin
          expFgd = capWord[24:13];
          expBkg = capWord[12:1];
        end
      end else if (!vde_in && drawY == 10'd480 && drawX == 10'd0) begin
        ctrlCount = 2;
      end
    end
  end

  always @(negedge pixel_clk) begin
    checkOutput("model_pix_fg",    {31'd0, pix_fg},    {31'd0, hist[2].pix});
    checkOutput("model_hsync_out", {31'd0, hsync_out}, {31'd0, hist[2].hs});
    checkOutput("model_vsync_out", {31'd0, vsync_out}, {31'd0, hist[2].vs});
    checkOutput("model_vde_out",   {31'd0, vde_out},   {31'd0, hist[2].vde});
    checkOutput("model_fgd_rgb",   {20'd0, fgd_rgb},   {20'd0, expFgd});
    checkOutput("model_bkg_rgb",   {20'd0, bkg_rgb},   {20'd0, expBkg});
    checkOutput("model_vram_addr", {22'd0, vram_addr}, {22'd0, expectedAddr()});
    if (hist[0].live) begin
      checkOutput("model_font_addr", {21'd0, font_addr}, {21'd0, hist[0].code, hist[0].y});
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E3779B9 + 32'h13579BDF;
    for (int i = 0; i < 2048; i++) font[i] = 8'((i * 37 + 11) ^ (i >> 3));
    font[11'h413] = 8'h18;
    resetModel();
    pixel_aresetn = 1'b0;
    drawX = 10'd700; drawY = 10'd3;
    vde_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;

    repeat (3) @(posedge pixel_clk);
    #1;
    checkOutput("reset_pix_fg",    {31'd0, pix_fg},    32'd0);
    checkOutput("reset_hsync_out", {31'd0, hsync_out}, 32'd1);
    checkOutput("reset_vsync_out", {31'd0, vsync_out}, 32'd1);
    checkOutput("reset_vde_out",   {31'd0, vde_out},   32'd0);
    checkOutput("reset_fgd_rgb",   {20'd0, fgd_rgb},   32'd0);
    checkOutput("reset_bkg_rgb",   {20'd0, bkg_rgb},   32'd0);
    pixel_aresetn = 1'b1;
    applyBlank(2);

    $display("[TB] glyph 'A' pixel");
    mem[0] = 32'h00000041;
    applyStimulus(3, 3, 1'b1, 1'b1, 1'b1);
    #1 checkOutput("addr_cell0", {22'd0, vram_addr}, 32'd0);
    applyBlank(1);
    checkOutput("font_addr_A_row3", {21'd0, font_addr}, 32'h413);
    applyBlank(2);
    checkOutput("pix_A_row3_x3", {31'd0, pix_fg}, 32'd1);

    $display("[TB] inverted glyph 'A' pixel");
    mem[0] = 32'h000000C1;
    applyStimulus(3, 3, 1'b1, 1'b1, 1'b1);
    #1 checkOutput("addr_cell0_inv", {22'd0, vram_addr}, 32'd0);
    applyBlank(3);
    checkOutput("pix_A_inverted", {31'd0, pix_fg}, 32'd0);

    $display("[TB] byte select within word 21");
    mem[21] = 32'hC4_53_A2_31;
    applyStimulus(37, 17, 1'b1, 1'b1, 1'b1);
    #1 checkOutput("addr_x37_y17", {22'd0, vram_addr}, 32'd21);
    applyStimulus(45, 17, 1'b1, 1'b1, 1'b1);
    checkOutput("font_addr_x37_k0", {21'd0, font_addr}, 32'h311);
    #1 checkOutput("addr_x45_y17", {22'd0, vram_addr}, 32'd21);
    applyBlank(1);
    checkOutput("font_addr_x45_k1", {21'd0, font_addr}, 32'h221);
    applyBlank(3);

    $display("[TB] active line sweeps and right-edge gating");
    for (int y = 19; y <= 35; y += 16) begin
      for (int x = 0; x < 80; x++) applyStimulus(x, y, 1'b1, 1'b1, 1'b1);
      for (int x = 636; x < 646; x++) applyStimulus(x, y, 1'b1, 1'b1, 1'b1);
      applyBlank(4);
    end

    $display("[TB] control register capture");
    mem[600] = 32'h01FFE000;
    applyStimulus(0, 480, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 480, 1'b0, 1'b1, 1'b1);
    #1 checkOutput("addr_ctrl_cycle", {22'd0, vram_addr}, 32'd600);
    applyStimulus(1, 480, 1'b0, 1'b1, 1'b1);
    #1 checkOutput("addr_after_ctrl", {22'd0, vram_addr}, 32'd0);
    applyStimulus(2, 480, 1'b0, 1'b1, 1'b1);
    checkOutput("fgd_white", {20'd0, fgd_rgb}, 32'hFFF);
    checkOutput("bkg_black", {20'd0, bkg_rgb}, 32'h000);
    applyBlank(2);
    mem[600] = 32'hFE2468AD;
    applyStimulus(0, 480, 1'b0, 1'b1, 1'b1);
    applyBlank(3);
    checkOutput("fgd_123", {20'd0, fgd_rgb}, 32'h123);
    checkOutput("bkg_456", {20'd0, bkg_rgb}, 32'h456);

    $display("[TB] hsync through blanking");
    applyStimulus(656, 100, 1'b0, 1'b0, 1'b1);
    applyStimulus(657, 100, 1'b0, 1'b1, 1'b1);
    applyStimulus(658, 100, 1'b0, 1'b1, 1'b1);
    applyStimulus(659, 100, 1'b0, 1'b1, 1'b1);
    checkOutput("hsync_delayed_low", {31'd0, hsync_out}, 32'd0);
    checkOutput("pix_blank_hsync",   {31'd0, pix_fg},    32'd0);
    applyBlank(1);
    checkOutput("hsync_delayed_high", {31'd0, hsync_out}, 32'd1);
    for (int i = 0; i < 12; i++) applyStimulus(660 + i, 101, 1'b0, 1'((i % 3) != 0), 1'b1);
    applyBlank(3);

    $display("[TB] reset mid-line");
    mem[0] = 32'h00000041;
    for (int i = 0; i < 4; i++) applyStimulus(3, 3, 1'b1, 1'b0, 1'b0);
    #2 pixel_aresetn = 1'b0;
    #1;
    checkOutput("midreset_pix_fg",    {31'd0, pix_fg},    32'd0);
    checkOutput("midreset_hsync_out", {31'd0, hsync_out}, 32'd1);
    checkOutput("midreset_vsync_out", {31'd0, vsync_out}, 32'd1);
    checkOutput("midreset_fgd_rgb",   {20'd0, fgd_rgb},   32'd0);
    checkOutput("midreset_bkg_rgb",   {20'd0, bkg_rgb},   32'd0);
    @(posedge pixel_clk);
    #1 pixel_aresetn = 1'b1;
    applyStimulus(3, 3, 1'b1, 1'b1, 1'b1);
    applyBlank(3);
    checkOutput("pix_after_reset", {31'd0, pix_fg}, 32'd1);
    checkOutput("fgd_after_reset", {20'd0, fgd_rgb}, 32'd0);
    applyBlank(4);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
